// File: rtl/run_ctrl_pkg.sv
// Shared types and constants for the CPU run controller and its tick generator.
package run_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'b000,
        StPre   = 3'b001,
        StRun   = 3'b010,
        StCheck = 3'b011,
        StPass  = 3'b100,
        StFail  = 3'b101
    } state_e;

    localparam int unsigned PRESC_W = 25;

    localparam logic [5:0] SW_K25   = 6'b111110;
    localparam logic [5:0] SW_K21   = 6'b111100;
    localparam logic [5:0] SW_K17   = 6'b111000;
    localparam logic [5:0] SW_K13   = 6'b110000;
    localparam logic [5:0] SW_K9    = 6'b100000;
    localparam logic [5:0] SW_K5    = 6'b000000;
    localparam logic [5:0] SW_PAUSE = 6'b111111;

    // Low k bits of the prescaler; an all-zero mask means no ticks at all.
    function automatic logic [PRESC_W-1:0] sw_tick_mask(input logic [5:0] sw);
        logic [PRESC_W-1:0] m;
        case (sw)
            SW_K25:  m = 25'h1FF_FFFF;
            SW_K21:  m = 25'h01F_FFFF;
            SW_K17:  m = 25'h001_FFFF;
            SW_K13:  m = 25'h000_1FFF;
            SW_K9:   m = 25'h000_01FF;
            SW_K5:   m = 25'h000_001F;
            default: m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [1:0] led_code(input state_e s);
        logic [1:0] c;
        case (s)
            StIdle:  c = 2'b00;
            StPre:   c = 2'b01;
            StRun:   c = 2'b10;
            default: c = 2'b11;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/run_ctrl_tick.sv
// CPU clock-enable generator: free-running prescaler with a switch-selected tick period.
module tick_gen
    import run_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [5:0] Switch,
    output logic       tick
);
    logic [PRESC_W-1:0] r_presc;
    logic [PRESC_W-1:0] w_mask;
    logic               w_hit;
    logic               r_tick;

    assign w_mask = sw_tick_mask(Switch);
    assign w_hit  = (w_mask != '0) && ((r_presc & w_mask) == w_mask);
    assign tick   = r_tick;

    // Prescaler is deliberately never reset so the tick phase is unaffected by rst.
    always_ff @(posedge clk) begin
        r_presc <= r_presc + PRESC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tick <= 1'b0;
        end else begin
            r_tick <= en && w_hit;
        end
    end

endmodule

// File: rtl/run_ctrl.sv
// Run controller: ticks the CPU, times the run to the end PC, then checks result-array order.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned N_WORDS    = 16,
    parameter int unsigned RST_TICKS  = 4,
    parameter logic [31:0] MAX_CYCLES = 32'hFFFF_FFFF,
    parameter bit          SIGNED_CMP = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key1,
    input  logic [5:0]  Switch,
    input  logic [7:0]  pc_in,
    input  logic [31:0] mem_data,
    output logic        cpu_rst,
    output logic        cpu_tick,
    output logic        mem_sel,
    output logic [31:0] rd_addr,
    output logic [31:0] clk_count_out,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic [1:0]  LED_clk
);
    state_e      r_state, w_state_d;
    logic        r_key1_prev;
    logic [31:0] r_pre_cnt, w_pre_cnt_d;
    logic [31:0] r_count, w_count_d;
    logic [31:0] r_chk_idx, w_chk_idx_d;
    logic [31:0] r_prev_word;
    logic [31:0] w_rd_addr_d;
    logic [31:0] w_count_inc;
    logic        w_key_rise, w_tick_en, w_pc_end, w_word_lt;
    logic        r_cpu_rst, r_mem_sel, r_done, r_pass, r_fail;
    logic [31:0] r_rd_addr;
    logic [1:0]  r_led;
    logic        w_unused_pc;

    assign w_key_rise  = key1 & ~r_key1_prev;
    assign w_pc_end    = (pc_in[7:6] == 2'b11);
    assign w_unused_pc = ^pc_in[5:0];
    assign w_count_inc = r_count + 32'd1;
    assign w_tick_en   = (w_state_d == StPre) || (w_state_d == StRun);
    assign w_word_lt   = SIGNED_CMP ? ($signed(mem_data) < $signed(r_prev_word))
                                    : (mem_data < r_prev_word);
    assign w_rd_addr_d = (w_chk_idx_d < 32'(N_WORDS)) ? w_chk_idx_d : 32'(N_WORDS - 1);

    tick_gen u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .en     (w_tick_en),
        .Switch (Switch),
        .tick   (cpu_tick)
    );

    always_comb begin
        w_state_d   = r_state;
        w_pre_cnt_d = r_pre_cnt;
        w_count_d   = r_count;
        w_chk_idx_d = r_chk_idx;
        if (r_state != StIdle && !key1) begin
            w_state_d = StIdle;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_key_rise) begin
                        w_state_d   = StPre;
                        w_count_d   = '0;
                        w_pre_cnt_d = '0;
                    end
                end
                StPre: begin
                    if (cpu_tick) begin
                        if (r_pre_cnt == 32'(RST_TICKS - 1)) begin
                            w_state_d = StRun;
                        end else begin
                            w_pre_cnt_d = r_pre_cnt + 32'd1;
                        end
                    end
                end
                StRun: begin
                    // The count never exceeds MAX_CYCLES: reaching it leaves RUN.
                    if (cpu_tick) begin
                        w_count_d = w_count_inc;
                        if (w_pc_end) begin
                            w_state_d   = StCheck;
                            w_chk_idx_d = '0;
                        end else if (w_count_inc == MAX_CYCLES) begin
                            w_state_d = StFail;
                        end
                    end
                end
                StCheck: begin
                    // In cycle idx, mem_data holds word idx-1 and r_prev_word holds word idx-2.
                    w_chk_idx_d = r_chk_idx + 32'd1;
                    if (r_chk_idx >= 32'd2 && w_word_lt) begin
                        w_state_d = StFail;
                    end else if (r_chk_idx == 32'(N_WORDS)) begin
                        w_state_d = StPass;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_key1_prev <= key1;
            r_pre_cnt   <= '0;
            r_count     <= '0;
            r_chk_idx   <= '0;
            r_prev_word <= '0;
            r_cpu_rst   <= 1'b1;
            r_mem_sel   <= 1'b0;
            r_rd_addr   <= '0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_led       <= 2'b00;
        end else begin
            r_state     <= w_state_d;
            r_key1_prev <= key1;
            r_pre_cnt   <= w_pre_cnt_d;
            r_count     <= w_count_d;
            r_chk_idx   <= w_chk_idx_d;
            r_prev_word <= mem_data;
            r_cpu_rst   <= (w_state_d == StIdle) || (w_state_d == StPre);
            r_mem_sel   <= (w_state_d == StCheck);
            r_rd_addr   <= (w_state_d == StCheck) ? w_rd_addr_d : '0;
            r_done      <= (w_state_d == StPass) || (w_state_d == StFail);
            r_pass      <= (w_state_d == StPass);
            r_fail      <= (w_state_d == StFail);
            r_led       <= led_code(w_state_d);
        end
    end

    assign cpu_rst       = r_cpu_rst;
    assign mem_sel       = r_mem_sel;
    assign rd_addr       = r_rd_addr;
    assign clk_count_out = r_count;
    assign done          = r_done;
    assign pass          = r_pass;
    assign fail          = r_fail;
    assign LED_clk       = r_led;

endmodule
